aes_inv_round_engine: RTL and testbench

Iterative AES-128 decryption datapath: accepts one 128-bit ciphertext block plus the full 1408-bit expanded key schedule, and executes the inverse cipher one round per clock. It is the decrypt-side counterpart of the forward round logic: same key-schedule bus format, same byte ordering, mirrored round sequence. It sits between the key-expansion block and the block-level stream interface, with valid/ready handshakes on both sides.

---
 rtl/aes_inv_round_engine.sv | 243 ++++++++++++++++++++++++
 tb/tb_aes_inv_round_engine.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_round_engine.sv
// ---------------------------------------------------------------------------
// aes_inv_round_engine
//
// Iterative AES-128 inverse cipher. Accepts one 128-bit ciphertext block with
// the full 1408-bit expanded key schedule and runs one decryption round per
// clock: initial AddRoundKey on accept, nine full inverse rounds, then a
// final round without InvMixColumns.
//
// Handshake rules (both sides): a transfer happens on a rising clock edge
// where valid and ready are both high. A producer holds valid and data
// stable until that edge. The engine never buffers a second block.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   key        expanded key schedule; round key r = key[1407-128*r -: 128]
//   in_data    ciphertext, byte 0 = [127:120], column-major
//   in_valid   ciphertext offered
//   in_ready   engine can accept (IDLE only)
//   out_data   plaintext, same byte order
//   out_valid  plaintext available
//   out_ready  consumer accepts plaintext
//   busy       high while rounds are being computed (ROUND or FINAL)
//
// Build option:
//   AES_INV_KEY_LATCH_EN  when defined, the key schedule is captured on the
//                         accept edge and all rounds use the captured copy.
//                         When undefined, rounds read key directly and key
//                         must stay stable from accept through FINAL.
// ---------------------------------------------------------------------------
module aes_inv_round_engine (
    input  logic          clk,
    input  logic          rst,
    input  logic [1407:0] key,
    input  logic [127:0]  in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [127:0]  out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // ---------------------------------------------------------------------
    // GF(2^8) helpers, reduction polynomial 0x11B
    // ---------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Returns {b*0e, b*0b, b*0d, b*09}
    function automatic logic [31:0] inv_mul_set(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return {x8 ^ x4 ^ x2, x8 ^ x2 ^ b, x8 ^ x4 ^ b, x8 ^ b};
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [31:0] m0, m1, m2, m3;
        // Field order in each m: [31:24]=x0e [23:16]=x0b [15:8]=x0d [7:0]=x09
        m0 = inv_mul_set(col[31:24]);
        m1 = inv_mul_set(col[23:16]);
        m2 = inv_mul_set(col[15:8]);
        m3 = inv_mul_set(col[7:0]);
        return {m0[31:24] ^ m1[23:16] ^ m2[15:8]  ^ m3[7:0],
                m0[7:0]   ^ m1[31:24] ^ m2[23:16] ^ m3[15:8],
                m0[15:8]  ^ m1[7:0]   ^ m2[31:24] ^ m3[23:16],
                m0[23:16] ^ m1[15:8]  ^ m2[7:0]   ^ m3[31:24]};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] r;
        for (int c = 0; c < 4; c++) begin
            r[127 - 32*c -: 32] = inv_mix_column(s[127 - 32*c -: 32]);
        end
        return r;
    endfunction

    // Byte index i = 4*col + row; row r is rotated right by r positions,
    // so output column c takes its row-r byte from input column c-r.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        for (int c = 0; c < 4; c++) begin
            for (int rw = 0; rw < 4; rw++) begin
                r[127 - 8*(4*c + rw) -: 8] = s[127 - 8*(4*((c - rw + 4) % 4) + rw) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) begin
            r[127 - 8*i -: 8] = INV_SBOX[s[127 - 8*i -: 8]];
        end
        return r;
    endfunction

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    state_t         fsm_q;
    state_t         fsm_d;
    logic [3:0]     rcnt;
    logic [127:0]   state_reg;
    logic           accept;
    logic [1407:0]  key_src;
    logic [127:0]   rk [16];
    logic [127:0]   inv_sr_sb;
    logic [127:0]   round_out;
    logic [127:0]   final_out;

    assign accept = (fsm_q == IDLE) && in_valid;

`ifdef AES_INV_KEY_LATCH_EN
    logic [1407:0] key_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_reg <= '0;
        end else if (accept) begin
            key_reg <= key;
        end
    end

    assign key_src = key_reg;
`else
    assign key_src = key;
`endif

    // Round keys as an array; entries 11..15 are unreachable (rcnt <= 9).
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            rk[i] = '0;
        end
        for (int i = 0; i < 11; i++) begin
            rk[i] = key_src[1407 - 128*i -: 128];
        end
    end

    assign inv_sr_sb = inv_sub_bytes(inv_shift_rows(state_reg));
    assign round_out = inv_mix_columns(inv_sr_sb ^ rk[rcnt]);
    assign final_out = inv_sr_sb ^ rk[0];

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    always_comb begin
        fsm_d    = fsm_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        case (fsm_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) fsm_d = ROUND;
            end
            ROUND: begin
                busy = 1'b1;
                if (rcnt == 4'd1) fsm_d = FINAL;
            end
            FINAL: begin
                busy  = 1'b1;
                fsm_d = DONE;
            end
            DONE: begin
                if (out_ready) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rcnt      <= 4'd0;
            state_reg <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        // Round key 10 comes from the live bus: a latched
                        // copy would only be loaded on this same edge.
                        state_reg <= in_data ^ key[127:0];
                        rcnt      <= 4'd9;
                    end
                end
                ROUND: begin
                    state_reg <= round_out;
                    rcnt      <= rcnt - 4'd1;
                end
                FINAL: begin
                    out_data  <= final_out;
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_round_engine.sv
// ---------------------------------------------------------------------------
// tb_aes_inv_round_engine
//
// Directed bench for aes_inv_round_engine using FIPS-197 vectors (C.1 and
// A.1/B) with the expanded key schedules written out as constants. Inputs
// are driven 1 time unit after each rising edge and outputs are sampled
// at the same point.
// ---------------------------------------------------------------------------
module tb_aes_inv_round_engine;

    localparam logic [1407:0] KEY_C1 = {
        128'h000102030405060708090a0b0c0d0e0f,
        128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
        128'hb692cf0b643dbdf1be9bc5006830b3fe,
        128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
        128'h47f7f7bc95353e03f96c32bcfd058dfd,
        128'h3caaa3e8a99f9deb50f3af57adf622aa,
        128'h5e390f7df7a69296a7553dc10aa31f6b,
        128'h14f9701ae35fe28c440adf4d4ea9c026,
        128'h47438735a41c65b9e016baf4aebf7ad2,
        128'h549932d1f08557681093ed9cbe2c974e,
        128'h13111d7fe3944a17f307a78b4d2b30c5
    };
    localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;

    localparam logic [1407:0] KEY_A1 = {
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    localparam logic [127:0] CT_A1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_A1 = 128'h3243f6a8885a308d313198a2e0370734;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [1407:0] key = '0;
    logic [127:0]  in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [127:0]  out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    aes_inv_round_engine dut (
        .clk       (clk),
        .rst       (rst),
        .key       (key),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    // Clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Waits for out_valid with a bounded edge budget; returns edges waited.
    task automatic wait_out(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        chk("out_valid_timeout", {127'b0, out_valid}, 128'd1);
    endtask

    // Completes the output handshake and confirms the return to IDLE.
    task automatic handshake();
        out_ready = 1'b1;
        step();
        chk("hs_out_valid_low", {127'b0, out_valid}, 128'd0);
        chk("hs_in_ready_high", {127'b0, in_ready}, 128'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        int n;
        int acc1;
        int acc2;

        // ---------------- reset state ----------------
        step();
        step();
        chk("rst_in_ready", {127'b0, in_ready}, 128'd1);
        chk("rst_busy", {127'b0, busy}, 128'd0);
        chk("rst_out_valid", {127'b0, out_valid}, 128'd0);
        chk("rst_out_data", out_data, 128'd0);
        rst = 1'b1;
        step();

        // ---------------- C.1 with latency ----------------
        key      = KEY_C1;
        in_data  = CT_C1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("c1_busy_after_accept", {127'b0, busy}, 128'd1);
        chk("c1_in_ready_low", {127'b0, in_ready}, 128'd0);
        wait_out(n);
        chk("c1_latency", 128'(n), 128'd10);
        chk("c1_plaintext", out_data, PT_C1);
        chk("c1_busy_done", {127'b0, busy}, 128'd0);
        handshake();

        // ---------------- A.1 with backpressure ----------------
        key      = KEY_A1;
        in_data  = CT_A1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_out(n);
        chk("a1_plaintext", out_data, PT_A1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_out_data", out_data, PT_A1);
            chk("bp_out_valid", {127'b0, out_valid}, 128'd1);
            chk("bp_in_ready", {127'b0, in_ready}, 128'd0);
        end
        handshake();

        // ---------------- input while busy ----------------
        key      = KEY_C1;
        in_data  = CT_C1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        in_data  = CT_A1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("busy_pulse_ignored_busy", {127'b0, busy}, 128'd1);
        wait_out(n);
        chk("busy_first_result", out_data, PT_C1);
        // Offer the second block while DONE; it must wait for the handshake.
        key       = KEY_A1;
        in_data   = CT_A1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        chk("busy_no_accept_in_done", {127'b0, busy}, 128'd0);
        chk("busy_idle_after_hs", {127'b0, in_ready}, 128'd1);
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        chk("busy_second_accepted", {127'b0, busy}, 128'd1);
        wait_out(n);
        chk("busy_second_result", out_data, PT_A1);
        handshake();

        // ---------------- back-to-back ----------------
        key       = KEY_C1;
        in_data   = CT_C1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        acc1    = cyc;
        in_data = CT_A1;
        chk("b2b_first_busy", {127'b0, busy}, 128'd1);
        wait_out(n);
        chk("b2b_first_result", out_data, PT_C1);
        key = KEY_A1;
        step();
        chk("b2b_hs_out_valid", {127'b0, out_valid}, 128'd0);
        step();
        acc2     = cyc;
        in_valid = 1'b0;
        chk("b2b_second_busy", {127'b0, busy}, 128'd1);
        chk("b2b_issue_interval", 128'(acc2 - acc1), 128'd12);
        wait_out(n);
        chk("b2b_second_result", out_data, PT_A1);
        step();
        chk("b2b_final_out_valid", {127'b0, out_valid}, 128'd0);
        out_ready = 1'b0;

        // ---------------- key change after accept ----------------
        key      = KEY_C1;
        in_data  = CT_C1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        key = '0;
        wait_out(n);
`ifdef AES_INV_KEY_LATCH_EN
        chk("keylatch_result", out_data, PT_C1);
`else
        checks++;
        assert (out_data !== PT_C1) else begin
            errors++;
            $error("FAIL nolatch_result: observed %h expected anything but %h", out_data, PT_C1);
        end
`endif
        handshake();

        // ---------------- reset mid-ROUND ----------------
        key      = KEY_C1;
        in_data  = CT_C1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", {127'b0, out_valid}, 128'd0);
        chk("midrst_out_data", out_data, 128'd0);
        chk("midrst_in_ready", {127'b0, in_ready}, 128'd1);
        chk("midrst_busy", {127'b0, busy}, 128'd0);
        step();
        step();
        rst = 1'b1;
        for (int i = 0; i < 14; i++) begin
            step();
        end
        chk("midrst_no_stale_valid", {127'b0, out_valid}, 128'd0);
        chk("midrst_no_stale_data", out_data, 128'd0);
        // First accept right after deassertion.
        rst = 1'b0;
        step();
        rst      = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("post_rst_accept", {127'b0, busy}, 128'd1);
        wait_out(n);
        chk("post_rst_latency", 128'(n), 128'd10);
        chk("post_rst_result", out_data, PT_C1);
        handshake();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
